mem_responder: RTL

Byte-wide memory target on the CPU's shared tri-state memory bus: the responder end of the CPU's instruction fetch and its load/store traffic. The block decodes an address window, serves reads by driving `memory_data_bus` after a parameterised number of wait cycles, and commits writes on the clock edge. It sits beside the CPU at top level. Several instances with disjoint windows may share one bus.

---
 rtl/cpu_bus_pkg.sv | 8 +
 rtl/mem_array.sv | 19 +
 rtl/mem_responder.sv | 69 ++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared widths, byte/address types and responder states for the CPU memory bus
package cpu_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE} mem_resp_state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: byte storage with synchronous write and asynchronous read
module mem_array
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter string INIT_FILE = "",
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  byte_t         wdata,
  output byte_t         rdata
);
  byte_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: windowed byte memory target on the shared tri-state CPU memory bus
module mem_responder
  import cpu_bus_pkg::*;
#(
  parameter addr_t BASE_ADDR = 16'h0000,
  parameter int DEPTH = 256,
  parameter int READ_LATENCY = 0,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] memory_data_bus,
  input  logic [ADDR_W-1:0] memory_address_bus,
  input  logic              memory_write_en,
  input  logic              memory_chip_sel,
  output logic              mem_ready
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
  localparam mem_resp_state_t START_ST = READ_LATENCY == 1 ? RD_DRIVE : RD_WAIT;
  mem_resp_state_t state, state_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  addr_t lat_addr, lat_addr_n, offset;
  logic sel, hit, rd_hit, wr_hit, hold, restart, drive;
  byte_t rdata;
  assign offset = memory_address_bus - BASE_ADDR;
  assign sel = memory_chip_sel === 1'b1;
  assign hit = sel && ({1'b0, offset} < 17'(DEPTH));
  assign rd_hit = hit && !memory_write_en;
  assign wr_hit = hit && memory_write_en;
  assign hold = state != IDLE && rd_hit && memory_address_bus == lat_addr;
  assign restart = rd_hit && READ_LATENCY != 0;
  mem_array #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_array (
    .clk   (clk),
    .we    (wr_hit),
    .addr  (offset[AW-1:0]),
    .wdata (memory_data_bus),
    .rdata (rdata)
  );
  // a stable read keeps counting/driving; any change re-evaluates this cycle as a fresh request
  always_comb begin
    state_n = IDLE;
    wait_cnt_n = wait_cnt;
    lat_addr_n = lat_addr;
    drive = rd_hit && READ_LATENCY == 0;
    if (hold) begin
      drive = state == RD_DRIVE;
      state_n = state == RD_WAIT && wait_cnt <= 4'd1 ? RD_DRIVE : state;
      wait_cnt_n = wait_cnt == '0 ? '0 : wait_cnt - 4'd1;
    end else if (restart) begin
      state_n = START_ST;
      wait_cnt_n = LAT_M1;
      lat_addr_n = memory_address_bus;
    end
  end
  // state register; storage is deliberately untouched by reset
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      lat_addr <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_cnt_n;
      lat_addr <= lat_addr_n;
    end
  assign mem_ready = !rst && (drive || wr_hit);
  assign memory_data_bus = drive && !rst ? rdata : 'z;
endmodule
